// File: rtl/seq_alu_accum.sv
// seq_alu_accum: registered W-bit ALU with a 2W-bit result/accumulator.
// Single-cycle ops complete at the accepting edge. Opcode 7 runs a W-cycle
// shift-add unsigned multiply with a busy/done handshake. The low half of
// the result can replace operand B, which allows chained operations.
module seq_alu_accum #(
  parameter int W = 4
) (
  input  logic           clk,
  input  logic           resetn,
  input  logic           start,
  input  logic [2:0]     opcode,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  input  logic           use_acc,
  output logic [2*W-1:0] result,
  output logic           busy,
  output logic           done
);

  localparam int CW = $clog2(W) + 1;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_MUL  = 1'b1
  } state_t;

  state_t             r_state, w_state_nxt;
  logic [2*W-1:0]     r_result, w_result_nxt;
  logic               r_done, w_done_nxt;
  logic [W-1:0]       r_mcand, w_mcand_nxt;
  logic [W-1:0]       r_mplier, w_mplier_nxt;
  logic [2*W-1:0]     r_prod, w_prod_nxt;
  logic [CW-1:0]      r_count, w_count_nxt;

  logic [W-1:0]       w_opb;
  logic [W:0]         w_inc;
  logic [W:0]         w_sum;
  logic [W:0]         w_diff;
  logic [2*W-1:0]     w_alu;
  logic [2*W-1:0]     w_addend;
  logic [2*W-1:0]     w_prod_add;
  logic               w_mul_last;

  // Place a (W+1)-bit carry/borrow result in the low bits of the 2W-bit result.
  function automatic logic [2*W-1:0] zext_carry(input logic [W:0] v);
    return {{(W-1){1'b0}}, v};
  endfunction

  // Operand selection and single-cycle ALU result; carry and borrow come out as bit W.
  always_comb begin
    w_opb  = use_acc ? r_result[W-1:0] : b;
    w_inc  = {1'b0, a} + {{W{1'b0}}, 1'b1};
    w_sum  = {1'b0, a} + {1'b0, w_opb};
    w_diff = {1'b0, a} - {1'b0, w_opb};
    w_alu  = r_result;
    case (opcode)
      3'd0:    w_alu = zext_carry(w_inc);
      3'd1:    w_alu = zext_carry(w_sum);
      3'd2:    w_alu = zext_carry(w_diff);
      3'd3:    w_alu = {a | w_opb, a ^ w_opb};
      3'd4:    w_alu = {{(2*W-1){1'b0}}, |{a, w_opb}};
      3'd5:    w_alu = {a, w_opb};
      default: w_alu = r_result;
    endcase
  end

  // One shift-add step: add the multiplicand shifted by the step count when the multiplier LSB is set.
  always_comb begin
    w_addend   = r_mplier[0] ? ({{W{1'b0}}, r_mcand} << r_count) : '0;
    w_prod_add = r_prod + w_addend;
    w_mul_last = (r_count == CW'(W - 1));
  end

  // Next-state and datapath updates; anything not assigned below holds its value.
  always_comb begin
    w_state_nxt  = r_state;
    w_result_nxt = r_result;
    w_done_nxt   = 1'b0;
    w_mcand_nxt  = r_mcand;
    w_mplier_nxt = r_mplier;
    w_prod_nxt   = r_prod;
    w_count_nxt  = r_count;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          if (opcode == 3'd7) begin
            w_state_nxt  = S_MUL;
            w_mcand_nxt  = a;
            w_mplier_nxt = w_opb;
            w_prod_nxt   = '0;
            w_count_nxt  = '0;
          end else begin
            w_result_nxt = w_alu;
            w_done_nxt   = 1'b1;
          end
        end
      end
      S_MUL: begin
        w_prod_nxt   = w_prod_add;
        w_mplier_nxt = r_mplier >> 1;
        w_count_nxt  = r_count + CW'(1);
        if (w_mul_last) begin
          w_result_nxt = w_prod_add;
          w_done_nxt   = 1'b1;
          w_state_nxt  = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any multiply and wins over start.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state  <= S_IDLE;
      r_result <= '0;
      r_done   <= 1'b0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_prod   <= '0;
      r_count  <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_result <= w_result_nxt;
      r_done   <= w_done_nxt;
      r_mcand  <= w_mcand_nxt;
      r_mplier <= w_mplier_nxt;
      r_prod   <= w_prod_nxt;
      r_count  <= w_count_nxt;
    end
  end

  assign result = r_result;
  assign busy   = (r_state == S_MUL);
  assign done   = r_done;

endmodule

// File: tb/tb_seq_alu_accum.sv
// Testbench for seq_alu_accum (W=4): scoreboard of expected results with due cycles.
module tb_seq_alu_accum;
  localparam int W = 4;

  logic           clk = 1'b0;
  logic           resetn = 1'b0;
  logic           start = 1'b0;
  logic [2:0]     opcode = '0;
  logic [W-1:0]   a = '0;
  logic [W-1:0]   b = '0;
  logic           use_acc = 1'b0;
  logic [2*W-1:0] result;
  logic           busy;
  logic           done;

  seq_alu_accum #(.W(W)) dut (
    .clk(clk), .resetn(resetn), .start(start), .opcode(opcode),
    .a(a), .b(b), .use_acc(use_acc),
    .result(result), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] exp;
    int         due;
  } exp_t;

  exp_t       sb[$];
  int         cyc = 0;
  int         n_checks = 0;
  int         n_fail = 0;
  bit         mon_en = 1'b0;
  logic [7:0] m_acc = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Reference behaviour computed with plain integer arithmetic.
  function automatic logic [7:0] model(input int op, input int x, input int y, input logic [7:0] acc);
    int r;
    case (op)
      0: r = x + 1;
      1: r = x + y;
      2: r = ((x < y) ? 16 : 0) + ((x - y + 16) % 16);
      3: r = ((x | y) * 16) + (x ^ y);
      4: r = ((x | y) != 0) ? 1 : 0;
      5: r = x * 16 + y;
      6: r = int'(acc);
      default: r = x * y;
    endcase
    return r[7:0];
  endfunction

  // Check done/result whenever an expected entry falls due; otherwise done must stay low.
  always @(negedge clk) begin
    if (mon_en) begin
      if (sb.size() > 0 && cyc >= sb[0].due) begin
        chk("done_pulse", done, 1'b1);
        chk("result", result, sb[0].exp);
        void'(sb.pop_front());
      end else begin
        chk("done_quiet", done, 1'b0);
      end
    end
  end

  // Drive one request (called just after a negedge); returns at the next negedge with start still high.
  task automatic issue(input logic [2:0] op, input logic [3:0] ia, input logic [3:0] ib, input logic ua);
    logic [3:0] bb;
    logic [7:0] e;
    exp_t       it;
    opcode  = op;
    a       = ia;
    b       = ib;
    use_acc = ua;
    start   = 1'b1;
    bb      = ua ? m_acc[3:0] : ib;
    e       = model(int'(op), int'(ia), int'(bb), m_acc);
    m_acc   = e;
    it.exp  = e;
    it.due  = cyc + 1 + ((op == 3'd7) ? W : 0);
    sb.push_back(it);
    @(negedge clk);
  endtask

  task automatic idle();
    start = 1'b0;
    @(negedge clk);
  endtask

  task automatic mul_op(input logic [3:0] ia, input logic [3:0] ib, input logic ua, input bit pulse);
    issue(3'd7, ia, ib, ua);
    chk("busy_1", busy, 1'b1);
    chk("mul_hold", result[3:0], ua ? result[3:0] : result[3:0]);
    start = 1'b0;
    for (int i = 2; i <= W; i++) begin
      @(negedge clk);
      chk("busy_n", busy, 1'b1);
      start = pulse && (i == 2);
      if (pulse) begin
        opcode = 3'd5;
        a      = ~a;
        b      = ~b;
      end
    end
    @(negedge clk);
    chk("busy_end", busy, 1'b0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    chk("rst_result", result, 8'h00);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    mon_en = 1'b1;

    issue(3'd1, 4'h7, 4'h9, 1'b0);
    idle();
    chk("add_busy", busy, 1'b0);
    chk("add_val", result, 8'h10);

    issue(3'd2, 4'h3, 4'h5, 1'b0);
    idle();
    issue(3'd0, 4'hF, 4'h0, 1'b0);
    idle();

    issue(3'd5, 4'h5, 4'hA, 1'b0);
    issue(3'd1, 4'h1, 4'hF, 1'b1);
    idle();
    chk("chain_val", result, 8'h0B);

    issue(3'd3, 4'hC, 4'h3, 1'b0);
    issue(3'd4, 4'hC, 4'h3, 1'b0);
    issue(3'd6, 4'hC, 4'h3, 1'b0);
    idle();

    mul_op(4'hF, 4'hF, 1'b0, 1'b1);
    chk("mul_ff", result, 8'hE1);
    idle();

    issue(3'd5, 4'h2, 4'hB, 1'b0);
    idle();
    mul_op(4'hA, 4'h0, 1'b1, 1'b0);
    chk("mul_acc", result, 8'h6E);
    idle();

    // Reset in the second multiply cycle, with a competing start.
    issue(3'd7, 4'h6, 4'h7, 1'b0);
    start = 1'b0;
    @(negedge clk);
    resetn  = 1'b0;
    start   = 1'b1;
    opcode  = 3'd1;
    a       = 4'h3;
    b       = 4'h3;
    use_acc = 1'b0;
    sb.delete();
    m_acc   = '0;
    @(negedge clk);
    resetn = 1'b1;
    start  = 1'b0;
    chk("mrst_result", result, 8'h00);
    chk("mrst_busy", busy, 1'b0);
    chk("mrst_done", done, 1'b0);
    @(negedge clk);
    chk("mrst_idle_busy", busy, 1'b0);
    issue(3'd1, 4'h2, 4'h3, 1'b0);
    idle();
    chk("post_rst_add", result, 8'h05);

    for (int k = 0; k < 24; k++) begin
      issue(3'($urandom_range(0, 6)), 4'($urandom), 4'($urandom), 1'($urandom));
    end
    idle();
    mul_op(4'($urandom), 4'($urandom), 1'b1, 1'b0);
    idle();

    for (int k = 0; k < 20 && sb.size() > 0; k++) @(negedge clk);
    chk("drain", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
